// File: rtl/xor_rotl_arbiter.sv
// xor_rotl_arbiter
//   Round-robin front end for a shared XOR-then-rotate-left datapath.
//   NUM_REQ requesters offer (A, B, rot) under valid/ready. One requester
//   is granted per cycle. Its rotl(A ^ B, rot mod DATA_WIDTH) is captured,
//   together with its index, in a single registered output slot that the
//   downstream side can stall.
//
// Ports
//   clk         rising-edge clock
//   resetn      synchronous active-low reset
//   req_valid   per-requester request valid
//   req_ready   per-requester accept (one-hot or zero)
//   req_a/b     operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_rot     rotate-left amount, requester i at [i*SEL_W +: SEL_W]
//   out_valid   output slot holds a result
//   out_ready   downstream accept
//   out_data    rotated result
//   out_id      index of the requester that produced out_data
//   done_count  results handed downstream, wraps at 16 bits
module xor_rotl_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  localparam int SEL_W     = $clog2(DATA_WIDTH) + 1,
  localparam int ID_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0]      req_rot,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]               out_id,
  output logic [15:0]                   done_count
);

  localparam int SHIFT_W = $clog2(DATA_WIDTH);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e                   slot_q, slot_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]         out_id_q, out_id_d;
  logic [ID_W-1:0]         last_ptr_q, last_ptr_d;
  logic [15:0]             done_count_q, done_count_d;

  logic                    grant_found;
  logic [ID_W-1:0]         grant_id;
  logic [ID_W-1:0]         cand;
  logic                    can_accept;
  logic                    accept;
  logic                    out_xfer;

  logic [DATA_WIDTH-1:0]   op_x;
  logic [SHIFT_W-1:0]      shamt;
  logic [2*DATA_WIDTH-1:0] doubled;
  logic [DATA_WIDTH-1:0]   result;

  // Round-robin search: start one past the last winner and wrap upward.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      // NOTE: blocking assignments here -- cand is written and read in the
      // same evaluation pass, which only works with '=' in combinational code.
      cand = ID_W'((int'(last_ptr_q) + off) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Reset is folded in so req_ready stays low in any cycle resetn is low.
  assign can_accept = resetn & ((slot_q == SLOT_EMPTY) | out_ready);
  assign accept     = grant_found & can_accept;
  assign req_ready  = accept ? (NUM_REQ'(1) << grant_id) : '0;
  assign out_xfer   = (slot_q == SLOT_FULL) & out_ready;

  // Shared datapath on the granted requester's operands. The upper half of
  // {x, x} << s equals (x << s) | (x >> (W - s)) and is exact for s = 0.
  assign op_x    = req_a[grant_id*DATA_WIDTH +: DATA_WIDTH]
                 ^ req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign shamt   = req_rot[grant_id*SEL_W +: SHIFT_W];
  assign doubled = {op_x, op_x} << shamt;
  assign result  = doubled[2*DATA_WIDTH-1 -: DATA_WIDTH];

  // Slot next state and captured result.
  always_comb begin
    slot_d       = slot_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    last_ptr_d   = last_ptr_q;
    done_count_d = done_count_q;

    if (out_xfer) begin
      done_count_d = done_count_q + 16'd1;
    end

    case (slot_q)
      SLOT_EMPTY: if (accept) slot_d = SLOT_FULL;
      SLOT_FULL:  if (!accept && out_ready) slot_d = SLOT_EMPTY;
      default:    slot_d = SLOT_EMPTY;
    endcase

    // A stalled full slot has can_accept low, so its contents stay put.
    if (accept) begin
      out_data_d = result;
      out_id_d   = grant_id;
      last_ptr_d = grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: the output data/id registers are reset too, because their
      // post-reset value (zero) is visible on the ports.
      slot_q       <= SLOT_EMPTY;
      out_data_q   <= '0;
      out_id_q     <= '0;
      last_ptr_q   <= ID_W'(NUM_REQ - 1);
      done_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for every state register.
      slot_q       <= slot_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      last_ptr_q   <= last_ptr_d;
      done_count_q <= done_count_d;
    end
  end

  assign out_valid  = (slot_q == SLOT_FULL);
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_xor_rotl_arbiter.sv
// Self-checking bench for xor_rotl_arbiter (DATA_WIDTH=8, NUM_REQ=4).
// Directed scenarios followed by a randomized run, all compared against a
// behavioural model of the arbiter kept in this file.
module tb_xor_rotl_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int SW = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             resetn;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR*SW-1:0] req_rot;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_id;
  logic [15:0]      done_count;

  always #5 clk = ~clk;

  xor_rotl_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_rot    (req_rot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .done_count (done_count)
  );

  int n_total = 0;
  int n_pass  = 0;
  string phase = "init";

  // Reference model state.
  bit m_full = 1'b0;
  int m_data = 0;
  int m_id   = 0;
  int m_done = 0;
  int m_last = NR - 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, exp);
  endtask

  function automatic int ref_result(input int a, input int b, input int rot);
    int x, s;
    x = (a ^ b) & 255;
    s = rot % DW;
    return ((x << s) | (x >> (DW - s))) & 255;
  endfunction

  function automatic int ref_grant(input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(m_last + k) % NR]) return (m_last + k) % NR;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input int a, input int b, input int rot);
    req_a[i*DW +: DW]   = DW'(a);
    req_b[i*DW +: DW]   = DW'(b);
    req_rot[i*SW +: SW] = SW'(rot);
  endtask

  task automatic random_ops();
    for (int i = 0; i < NR; i++)
      set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15));
  endtask

  // One clock: called just after an active edge with inputs already driven.
  task automatic cycle();
    int            g;
    bit            can;
    logic [NR-1:0] exp_rdy;
    #2;
    g       = ref_grant(req_valid);
    can     = resetn && (!m_full || out_ready);
    exp_rdy = (g >= 0 && can) ? NR'(1 << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (!resetn) begin
      m_full = 0; m_data = 0; m_id = 0; m_done = 0; m_last = NR - 1;
    end else begin
      if (m_full && out_ready) m_done = (m_done + 1) % 65536;
      if (exp_rdy != '0) begin
        m_data = ref_result(int'(req_a[g*DW +: DW]), int'(req_b[g*DW +: DW]),
                            int'(req_rot[g*SW +: SW]));
        m_id   = g;
        m_last = g;
        m_full = 1;
      end else if (m_full && out_ready) begin
        m_full = 0;
      end
    end
    check("out_valid", 32'(out_valid), 32'(m_full));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_id", 32'(out_id), 32'(m_id));
    check("done_count", 32'(done_count), 32'(m_done));
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '0;
    cycle();
    resetn = 1'b1;
  endtask

  int            fair_ids [6] = '{0, 1, 2, 3, 0, 1};
  logic [DW-1:0] held_data;
  logic [IW-1:0] held_id;
  logic [15:0]   held_done;

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_rot   = '0;
    out_ready = 1'b0;

    phase = "reset";
    cycle();
    cycle();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done_count), 32'd0);
    resetn = 1'b1;

    // Single operation: 0x12 ^ 0x34 = 0x26, rotl 4 -> 0x62.
    phase = "single";
    out_ready = 1'b1;
    set_req(0, 'h12, 'h34, 4);
    req_valid = 4'b0001;
    cycle();
    check("data", 32'(out_data), 32'h62);
    check("id", 32'(out_id), 32'd0);
    check("done_before", 32'(done_count), 32'd0);
    req_valid = '0;
    cycle();
    check("done_after", 32'(done_count), 32'd1);
    check("drained", 32'(out_valid), 32'd0);

    // Rotate edge cases.
    phase = "rot0";
    set_req(0, 'hA5, 'hFF, 0);
    req_valid = 4'b0001;
    cycle();
    check("data", 32'(out_data), 32'h5A);
    phase = "rot9";
    set_req(0, 'h80, 'h00, 9);
    cycle();
    check("data", 32'(out_data), 32'h01);
    phase = "rot7";
    set_req(0, 'h01, 'h00, 7);
    cycle();
    check("data", 32'(out_data), 32'h80);
    req_valid = '0;
    cycle();

    // Fairness from reset with every requester valid.
    phase = "fair";
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      random_ops();
      cycle();
      check("seq_id", 32'(out_id), 32'(fair_ids[k]));
    end

    // Back-pressure: hold a req0 result while req1/req2 wait.
    phase = "bp";
    req_valid = '0;
    cycle();
    set_req(0, 'h3C, 'h0F, 3);
    req_valid = 4'b0001;
    out_ready = 1'b0;
    cycle();
    held_data = out_data;
    held_id   = out_id;
    held_done = done_count;
    req_valid = 4'b0110;
    random_ops();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("hold_data", 32'(out_data), 32'(held_data));
      check("hold_id", 32'(out_id), 32'(held_id));
    end
    out_ready = 1'b1;
    cycle();
    check("accept_id", 32'(out_id), 32'd1);
    check("no_bubble", 32'(out_valid), 32'd1);
    check("done_inc", 32'(done_count), 32'(held_done + 16'd1));

    // Sparse traffic: req2 alone, an idle cycle, then req0 alone.
    phase = "sparse";
    req_valid = '0;
    cycle();
    req_valid = 4'b0100;
    cycle();
    check("id2", 32'(out_id), 32'd2);
    req_valid = '0;
    cycle();
    check("idle_valid", 32'(out_valid), 32'd0);
    req_valid = 4'b0001;
    cycle();
    check("id0", 32'(out_id), 32'd0);
    req_valid = '0;
    cycle();

    // Reset in the middle of traffic with done_count at 5.
    phase = "midrst";
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_valid = NR'($urandom_range(1, 15));
      random_ops();
      cycle();
    end
    check("pre_done", 32'(done_count), 32'd5);
    check("pre_valid", 32'(out_valid), 32'd1);
    resetn = 1'b0;
    cycle();
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_data", 32'(out_data), 32'd0);
    check("post_done", 32'(done_count), 32'd0);
    resetn    = 1'b1;
    req_valid = 4'b1111;
    cycle();
    check("first_grant", 32'(out_id), 32'd0);

    // Randomized traffic with occasional stalls and resets.
    phase = "random";
    for (int k = 0; k < 400; k++) begin
      resetn    = ($urandom_range(0, 59) != 0);
      req_valid = NR'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      random_ops();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xor_rotl_arbiter.md
# xor_rotl_arbiter

Round-robin arbiter and sequencer that shares one XOR-then-rotate-left datapath among NUM_REQ requesters. Each requester presents operands A, B and a rotate amount under a valid/ready handshake. The block grants one requester per cycle and computes (A ^ B) rotated left. It returns the result with the requester's index through a single registered, back-pressurable output stage. It sits in front of the XOR/rotate datapath and makes it safe for multiple clients.

## Interface
- DATA_WIDTH, 8: operand/result width; must be a power of two, >= 2
- NUM_REQ, 4: number of requesters, >= 2
- SEL_W (derived), $clog2(DATA_WIDTH)+1: rotate-amount width per requester
- ID_W (derived), max(1, $clog2(NUM_REQ)): requester index width

- clk  input  1  single clock, rising edge
- resetn  input  1  synchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high
- req_a  input  NUM_REQ*DATA_WIDTH  operand A, requester i in slice [i*DATA_WIDTH +: DATA_WIDTH]
- req_b  input  NUM_REQ*DATA_WIDTH  operand B, same packing
- req_rot  input  NUM_REQ*SEL_W  rotate-left amount, slice [i*SEL_W +: SEL_W]
- out_valid  output  1  result valid
- out_ready  input  1  downstream accept
- out_data  output  DATA_WIDTH  rotl(A ^ B, rot mod DATA_WIDTH)
- out_id  output  ID_W  index of requester that produced out_data
- done_count  output  16  completed-result counter, wraps at 0xFFFF -> 0x0000

## Operation
- Arithmetic:
  - x = A ^ B; effective shift s = rot mod DATA_WIDTH, i.e. the low $clog2(DATA_WIDTH) bits of rot.
  - out = (x << s) | (x >> (DATA_WIDTH - s)).
  - s = 0 passes x unchanged; the result is never forced to zero.
- Output slot, two states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- can_accept = EMPTY | (FULL & out_ready).
- Round-robin grant:
  - Search starts at (last_ptr + 1) mod NUM_REQ and scans upward with wrap.
  - The first requester with req_valid set is granted.
  - req_ready[i] = grant[i] & can_accept.
  - req_ready may depend combinationally on req_valid.
  - Requesters must not make req_valid depend on req_ready.
- Transfer on requester i: at a clock edge with req_valid[i] & req_ready[i]:
  - Register result into out_data and i into out_id.
  - Slot becomes/stays FULL.
  - last_ptr <= i.
- Output transfer (out_valid & out_ready):
  - done_count increments.
  - If no new request is accepted in the same cycle, slot -> EMPTY.
- Simultaneous output transfer and new accept: slot stays FULL with the new result; done_count still increments.
- While FULL & !out_ready:
  - out_data and out_id are held stable.
  - req_ready = 0.
  - last_ptr unchanged.
- No request valid: no grant; last_ptr unchanged.
- Reset (resetn low at an edge, including mid-operation):
  - out_valid = 0, out_data = 0, out_id = 0, done_count = 0.
  - last_ptr = NUM_REQ-1, so requester 0 has top priority after reset.
  - req_ready = 0 during any cycle resetn is low.
  - An in-flight result is discarded.

## Timing
- Latency: request accepted at edge t -> out_valid high from edge t (visible in cycle t+1).
- Throughput: one result per cycle when out_ready is held high.
- out_valid, out_data, out_id and done_count are registered outputs.
- req_ready is combinational from req_valid, last_ptr, slot state and out_ready.
- Once out_valid is asserted, it stays high with stable data until out_ready is sampled high.
- Requester hold rule: operands must stay stable while req_valid is high and req_ready is low.
- Starvation bound: a continuously valid requester is granted within NUM_REQ accepted transfers.

## Test plan
- Single op (DATA_WIDTH=8, NUM_REQ=4): req0 A=0x12, B=0x34, rot=4, out_ready=1 -> next cycle out_valid=1, out_data=0x62, out_id=0, done_count 0->1 after handshake.
- Rotate edges:
  - rot=0, A=0xA5, B=0xFF -> 0x5A.
  - rot=9, A=0x80, B=0x00 -> 0x01 (mod 8).
  - rot=7, A=0x01, B=0x00 -> 0x80.
- Fairness: all four req_valid held high, out_ready=1, from reset -> out_id sequence 0,1,2,3,0,1; exactly one req_ready high per cycle.
- Back-pressure: result FULL, out_ready low 3 cycles with req1,req2 valid -> out_data/out_id stable, req_ready=0000, then out_ready high -> same-cycle accept of req1, no bubble, done_count +1.
- Sparse traffic: only req2 valid, then only req0 -> grants 2 then 0; idle cycle between them leaves last_ptr=2 and out_valid=0 after drain.
- Reset mid-op: resetn low for one cycle while out_valid=1, done_count=5 -> next cycle out_valid=0, out_data=0, done_count=0; first grant after reset goes to req0 when all valid.
